// File: rtl/moving_ball_unit_if.sv
// moving_ball_unit_if: scan position, frame/launch pulses, collision buses
// and the ball's drawing/position outputs bundled for moving_ball_unit.
// The master side is the video/game logic and the slave side is the ball unit.
interface moving_ball_unit_if;
  logic [31:0] pxl_x;
  logic [31:0] pxl_y;
  logic        end_of_frame;
  logic        launch;
  logic [3:0]  frame_collision;
  logic [3:0]  player_collision;
  logic        ball_draw_request;
  logic [3:0]  ball_red;
  logic [3:0]  ball_green;
  logic [3:0]  ball_blue;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic        ball_moving;

  modport master (
    output pxl_x, pxl_y, end_of_frame, launch, frame_collision, player_collision,
    input  ball_draw_request, ball_red, ball_green, ball_blue, ball_x, ball_y, ball_moving
  );

  modport slave (
    input  pxl_x, pxl_y, end_of_frame, launch, frame_collision, player_collision,
    output ball_draw_request, ball_red, ball_green, ball_blue, ball_x, ball_y, ball_moving
  );
endinterface

// File: rtl/moving_ball_unit.sv
// moving_ball_unit: a rectangular ball sprite that sits parked until launched.
// After launch it moves once per frame and bounces off whatever the collision buses report.
// Hits are gathered over the whole frame. The bounce is applied after end_of_frame.
// The position then steps by the velocity and is clamped to the visible screen.
// Optional feature: define GRAVITY_EN to add +1 px/frame to vy after every move.
// The added gravity caps vy at +8.
module moving_ball_unit #(
  parameter int          OBJ_W      = 32,
  parameter int          OBJ_H      = 16,
  parameter int          SCREEN_W   = 640,
  parameter int          SCREEN_H   = 480,
  parameter int          INIT_X     = 100,
  parameter int          INIT_Y     = 100,
  parameter int          INIT_VX    = 4,
  parameter int          INIT_VY    = -2,
  parameter logic [7:0]  BALL_COLOR = 8'hE0
) (
  input logic               clk_25,
  input logic               reset,
  moving_ball_unit_if.slave bus
);

  typedef enum logic [1:0] {PARKED, WAIT_FRAME, BOUNCE, MOVE} state_t;

  localparam logic signed [11:0] MAX_X     = 12'(SCREEN_W - OBJ_W);
  localparam logic signed [11:0] MAX_Y     = 12'(SCREEN_H - OBJ_H);
  localparam logic [10:0]        INIT_X_L  = 11'(INIT_X);
  localparam logic [10:0]        INIT_Y_L  = 11'(INIT_Y);
  localparam logic signed [7:0]  INIT_VX_L = 8'(INIT_VX);
  localparam logic signed [7:0]  INIT_VY_L = 8'(INIT_VY);

  state_t            state;
  logic [10:0]       pos_x;
  logic [10:0]       pos_y;
  logic signed [7:0] vel_x;
  logic signed [7:0] vel_y;
  logic [3:0]        hits;
  logic [3:0]        hits_now;
  logic              moving;
  logic              draw;
  logic              in_box;
  logic              flip_x;
  logic              flip_y;
  logic signed [11:0] sum_x;
  logic signed [11:0] sum_y;
  logic [10:0]       next_x;
  logic [10:0]       next_y;

  // Negating -128 has no 8-bit result, so it saturates to +127.
  function automatic logic signed [7:0] negate(input logic signed [7:0] v);
    if (v == 8'sh80) return 8'sh7F;
    else return -v;
  endfunction

  // Clamp a signed 12-bit coordinate into [0, hi].
  function automatic logic [10:0] clamp(input logic signed [11:0] s,
                                        input logic signed [11:0] hi);
    if (s < 12'sd0) return 11'd0;
    else if (s > hi) return hi[10:0];
    else return s[10:0];
  endfunction

`ifdef GRAVITY_EN
  logic signed [7:0] vel_y_grav;
  // Downward acceleration per frame, capped at +8.
  always_comb begin
    vel_y_grav = vel_y + 8'sd1;
    if (vel_y >= 8'sd7) vel_y_grav = 8'sd8;
  end
`endif

  // Bounce decision, next-position arithmetic and sprite hit test.
  always_comb begin
    hits_now = hits | bus.frame_collision | bus.player_collision;
    flip_x   = (hits[0] && (vel_x < 8'sd0)) || (hits[2] && (vel_x > 8'sd0));
    flip_y   = (hits[1] && (vel_y < 8'sd0)) || (hits[3] && (vel_y > 8'sd0));
    sum_x    = $signed({1'b0, pos_x}) + $signed({{4{vel_x[7]}}, vel_x});
    sum_y    = $signed({1'b0, pos_y}) + $signed({{4{vel_y[7]}}, vel_y});
    next_x   = clamp(sum_x, MAX_X);
    next_y   = clamp(sum_y, MAX_Y);
    in_box   = ({21'd0, pos_x} <= bus.pxl_x) && (bus.pxl_x < {21'd0, pos_x} + 32'(OBJ_W)) &&
               ({21'd0, pos_y} <= bus.pxl_y) && (bus.pxl_y < {21'd0, pos_y} + 32'(OBJ_H));
  end

  // Ball state machine: park, collect hits over a frame, bounce, then move.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state  <= PARKED;
      pos_x  <= INIT_X_L;
      pos_y  <= INIT_Y_L;
      vel_x  <= INIT_VX_L;
      vel_y  <= INIT_VY_L;
      hits   <= 4'd0;
      moving <= 1'b0;
    end else begin
      case (state)
        PARKED: begin
          pos_x <= INIT_X_L;
          pos_y <= INIT_Y_L;
          vel_x <= INIT_VX_L;
          vel_y <= INIT_VY_L;
          hits  <= 4'd0;
          if (bus.launch) begin
            state  <= WAIT_FRAME;
            moving <= 1'b1;
          end
        end
        WAIT_FRAME: begin
          hits <= hits_now;
          if (bus.end_of_frame) state <= BOUNCE;
        end
        BOUNCE: begin
          if (flip_x) vel_x <= negate(vel_x);
          if (flip_y) vel_y <= negate(vel_y);
          state <= MOVE;
        end
        MOVE: begin
          pos_x <= next_x;
          pos_y <= next_y;
`ifdef GRAVITY_EN
          vel_y <= vel_y_grav;
`endif
          hits  <= 4'd0;
          state <= WAIT_FRAME;
        end
        default: begin
          state  <= PARKED;
          moving <= 1'b0;
        end
      endcase
    end
  end

  // Draw request lags the scan position by one pixel clock.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) draw <= 1'b0;
    else       draw <= in_box;
  end

  assign bus.ball_draw_request = draw;
  assign bus.ball_red          = draw ? {BALL_COLOR[7:5], 1'b0} : 4'd0;
  assign bus.ball_green        = draw ? {BALL_COLOR[4:2], 1'b0} : 4'd0;
  assign bus.ball_blue         = draw ? {BALL_COLOR[1:0], 2'b00} : 4'd0;
  assign bus.ball_x            = pos_x;
  assign bus.ball_y            = pos_y;
  assign bus.ball_moving       = moving;

endmodule

// File: doc/moving_ball_unit.md
MOVING_BALL_UNIT -- requirements
Module: moving_ball_unit

Interface
REQ-001 SHALL have parameter OBJ_W, default 32, ball width in pixels.
REQ-002 SHALL have parameter OBJ_H, default 16, ball height in pixels.
REQ-003 SHALL have parameter SCREEN_W, default 640, visible width; SCREEN_H, default 480, visible height.
REQ-004 SHALL have parameters INIT_X, INIT_Y, defaults 100, 100, top-left position after reset.
REQ-005 SHALL have parameters INIT_VX, INIT_VY, defaults 4, -2, signed pixels/frame after launch.
REQ-006 SHALL have parameter BALL_COLOR, default 8'hE0, RRRGGGBB fill colour.
REQ-007 SHALL have ports: clk_25 in 1 pixel clock; reset in 1 async active-high reset.
REQ-008 SHALL have ports: pxl_x in 32, pxl_y in 32 current scan pixel.
REQ-009 SHALL have ports: end_of_frame in 1 single-cycle frame pulse; launch in 1 single-cycle start pulse.
REQ-010 SHALL have ports: frame_collision in 4, player_collision in 4; bit0 left, bit1 top, bit2 right, bit3 bottom.
REQ-011 SHALL have ports: ball_draw_request out 1; ball_red, ball_green, ball_blue out 4 each.
REQ-012 SHALL have ports: ball_x out 11, ball_y out 11 current top-left; ball_moving out 1.

Function
REQ-013 SHALL register ball_draw_request one cycle after pxl_x/pxl_y, high iff ball_x<=pxl_x<ball_x+OBJ_W and ball_y<=pxl_y<ball_y+OBJ_H.
REQ-014 SHALL drive colours as {C[7:5],0}, {C[4:2],0}, {C[1:0],00} of BALL_COLOR when drawing, else 0.
REQ-015 SHALL implement FSM PARKED, WAIT_FRAME, BOUNCE, MOVE; ball_moving=1 in all but PARKED.
REQ-016 PARKED: position held at INIT, velocity held at INIT_VX/INIT_VY; launch -> WAIT_FRAME next cycle.
REQ-017 WAIT_FRAME: OR both collision buses into 4 sticky hit flags each cycle; end_of_frame -> BOUNCE.
REQ-018 Collision bits asserted in the same cycle as end_of_frame SHALL be included in that frame's flags.
REQ-019 BOUNCE (1 cycle): vx:=-vx if (left & vx<0) or (right & vx>0); vy:=-vy if (top & vy<0) or (bottom & vy>0); opposing hits with vx=0 leave vx unchanged.
REQ-020 MOVE (1 cycle): x:=clamp(x+vx, 0, SCREEN_W-OBJ_W), y:=clamp(y+vy, 0, SCREEN_H-OBJ_H); clear hit flags; -> WAIT_FRAME.
REQ-021 Position update visible on ball_x/ball_y exactly 2 cycles after end_of_frame.
REQ-022 end_of_frame or launch received in BOUNCE/MOVE SHALL be ignored; launch outside PARKED ignored.
REQ-023 Velocity SHALL be 8-bit signed; position arithmetic in 12-bit signed before clamping to 11-bit unsigned.
REQ-024 Negating -128 SHALL saturate to +127.

Reset
REQ-025 reset SHALL asynchronously force PARKED, ball_x=INIT_X, ball_y=INIT_Y, vx=INIT_VX, vy=INIT_VY, flags=0.
REQ-026 During reset, ball_draw_request, colours, ball_moving SHALL be 0; reset mid-frame discards pending hits.

Configuration
REQ-027 With GRAVITY_EN defined, MOVE SHALL also apply vy:=min(vy+1, +8) after the position update.
REQ-028 Without GRAVITY_EN, vy SHALL change only by bounce.

Verification
REQ-029 Reset, no launch, 3 end_of_frame pulses -> ball_x=100, ball_y=100, ball_moving=0.
REQ-030 launch, then end_of_frame -> two cycles later ball_x=104, ball_y=98 (gravity off).
REQ-031 pxl=(100,100) then (132,100) at rest -> draw_request 1 then 0, red=4'hE on first.
REQ-032 vx=4, frame_collision[2] pulsed mid-frame, end_of_frame -> vx=-4, ball_x decreases by 4.
REQ-033 ball_x=606, vx=+4, no collision -> ball_x clamps to 608, vx remains +4.
REQ-034 GRAVITY_EN, vy=-2, 12 frames -> vy sequence -1,0,...,8,8,8 (after first frame vy=-1).
